// File: rtl/seq_detect_scheduler.sv
// Shared Moore pattern-detector engine time-multiplexed across NCH serial requesters.
// Round-robin grant per cycle; per-channel history/fill contexts, match pulses and saturating counters.
module seq_detect_scheduler #(
   parameter int              NCH     = 4,
   parameter int              PLEN    = 3,
   parameter logic [PLEN-1:0] PATTERN = 3'b101,
   parameter int              CNT_W   = 8,
   localparam int             IW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic [NCH-1:0]   req,
   input  logic [NCH-1:0]   x,
   input  logic [NCH-1:0]   flush,
   input  logic             clr_cnt,
   output logic [NCH-1:0]   gnt,
   output logic [NCH-1:0]   match,
   input  logic [IW-1:0]    rd_ch,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [IW-1:0]    busy_ch
);
   localparam int FW = $clog2(PLEN + 1);

   logic [IW-1:0]    ptr;
   logic [PLEN-1:0]  hist  [NCH];
   logic [FW-1:0]    fill  [NCH];
   logic [CNT_W-1:0] count [NCH];

   logic [NCH-1:0]   eligible;
   logic [IW:0]      cand_sum;
   logic [IW-1:0]    cand;
   logic             gnt_vld_p0;
   logic [IW-1:0]    gnt_idx_p0;
   logic [PLEN-1:0]  hist_nxt_p0;
   logic [FW-1:0]    fill_nxt_p0;
   logic             hit_p0;
   logic [IW-1:0]    ptr_nxt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Stage p0: arbitration and engine evaluation on the granted context
   always_comb begin
      eligible   = req & ~flush;
      cand_sum   = '0;
      cand       = '0;
      gnt_vld_p0 = 1'b0;
      gnt_idx_p0 = '0;
      for (int k = 0; k < NCH; k++) begin
         cand_sum = {1'b0, ptr} + (IW+1)'(k);
         if (cand_sum >= (IW+1)'(NCH))
            cand_sum = cand_sum - (IW+1)'(NCH);
         cand = cand_sum[IW-1:0];
         if (!gnt_vld_p0 && eligible[cand]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = cand;
         end
      end
      if (!clear_n)
         gnt_vld_p0 = 1'b0;

      gnt = '0;
      if (gnt_vld_p0)
         gnt[gnt_idx_p0] = 1'b1;

      hist_nxt_p0 = {hist[gnt_idx_p0][PLEN-2:0], x[gnt_idx_p0]};
      fill_nxt_p0 = (fill[gnt_idx_p0] == FW'(PLEN)) ? fill[gnt_idx_p0]
                                                    : fill[gnt_idx_p0] + FW'(1);
      hit_p0      = gnt_vld_p0 && (fill_nxt_p0 == FW'(PLEN)) && (hist_nxt_p0 == PATTERN);
      ptr_nxt     = (gnt_idx_p0 == IW'(NCH - 1)) ? '0 : gnt_idx_p0 + IW'(1);
   end

   // Stage p1: context write-back, registered match pulse, counters
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         ptr     <= '0;
         busy_ch <= '0;
         match   <= '0;
         for (int i = 0; i < NCH; i++) begin
            hist[i]  <= '0;
            fill[i]  <= '0;
            count[i] <= '0;
         end
      end else begin
         match <= '0;
         if (gnt_vld_p0) begin
            match[gnt_idx_p0] <= hit_p0;
            ptr               <= ptr_nxt;
            busy_ch           <= gnt_idx_p0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (flush[i]) begin
               hist[i] <= '0;
               fill[i] <= '0;
            end else if (gnt_vld_p0 && (gnt_idx_p0 == IW'(i))) begin
               hist[i] <= hist_nxt_p0;
               fill[i] <= fill_nxt_p0;
            end
            if (clr_cnt)
               count[i] <= '0;
            else if (hit_p0 && (gnt_idx_p0 == IW'(i)))
               count[i] <= sat_inc(count[i]);
         end
      end
   end

   always_comb begin
      rd_cnt = '0;
      if (int'(rd_ch) < NCH)
         rd_cnt = count[rd_ch];
   end

endmodule
